// File: rtl/game_pkg.sv
// Shared types and constants for the game/score datapath.
//   game_state_t : IDLE / RUN / HOLD / OVER encoding consumed by the draw_* blocks
//   SCORE_W      : binary score width
//   BCD_W        : four-digit BCD score width
//   bcd_inc      : +1 on a four-digit packed BCD value (wraps 9999 -> 0000; callers saturate)
package game_pkg;

    localparam int unsigned SCORE_W = 14;
    localparam int unsigned BCD_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        OVER = 2'd3
    } game_state_t;

    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        logic             carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD score counter with a binary copy kept in lockstep.
//   clk      : system clock
//   reset    : asynchronous active-low reset
//   clear    : synchronous clear to zero (wins over inc)
//   inc      : increment by one, saturating at MAX_SCORE
//   bin      : registered binary score
//   bin_next : value bin takes at the next edge (for same-cycle high-score capture)
//   bcd      : registered BCD score, [15:12] = thousands
module bcd_counter4
    import game_pkg::*;
#(
    parameter int unsigned MAX_SCORE = 9999
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               inc,
    output logic [SCORE_W-1:0] bin,
    output logic [SCORE_W-1:0] bin_next,
    output logic [BCD_W-1:0]   bcd
);

    logic [SCORE_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               sat;

    // Saturation is decided on the binary value so both encodings stop together.
    assign sat = (bin_q == SCORE_W'(MAX_SCORE));

    always_comb begin
        bin_d = bin_q;
        bcd_d = bcd_q;
        if (clear) begin
            bin_d = '0;
            bcd_d = '0;
        end else if (inc && !sat) begin
            bin_d = bin_q + SCORE_W'(1);
            bcd_d = bcd_inc(bcd_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bin_q <= '0;
            bcd_q <= '0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
        end
    end

    assign bin      = bin_q;
    assign bin_next = bin_d;
    assign bcd      = bcd_q;

endmodule

// File: rtl/game_score_ctrl.sv
// Game-state and scoring stage: collide latch, single-pulse hit with hold-off, lives,
// binary + BCD score, session high score, IDLE/RUN/HOLD/OVER FSM.
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   frame_tick : one-clk pulse per game frame
//   collide    : goose/bean overlap level
//   miss       : one-clk pulse, bean hit the floor
//   start      : start/restart level (synchronised)
//   hit        : one-clk pulse on the frame_tick that registers a catch
//   score      : binary score
//   score_bcd  : BCD score
//   hi_score   : best finished-game score since reset
//   lives      : remaining lives
//   running    : in RUN or HOLD
//   game_over  : in OVER
module game_score_ctrl
    import game_pkg::*;
#(
    parameter int unsigned MAX_SCORE     = 9999,
    parameter int unsigned LIVES         = 3,
    parameter int unsigned HOLDOFF_TICKS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               collide,
    input  logic               miss,
    input  logic               start,
    output logic               hit,
    output logic [SCORE_W-1:0] score,
    output logic [BCD_W-1:0]   score_bcd,
    output logic [SCORE_W-1:0] hi_score,
    output logic [1:0]         lives,
    output logic               running,
    output logic               game_over
);

    localparam int unsigned    HO_W    = $clog2(HOLDOFF_TICKS + 1);
    localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF_TICKS - 1);

    game_state_t        state_q, state_d;
    logic               start_q;
    logic               latch_q, latch_d;
    logic               pend_q, pend_d;
    logic [HO_W-1:0]    holdoff_q, holdoff_d;
    logic [1:0]         lives_q, lives_d;
    logic [SCORE_W-1:0] hi_q, hi_d;
    logic               start_edge;
    logic               ctr_clear, ctr_inc, go_over;
    logic [SCORE_W-1:0] score_next;

    assign start_edge = start & ~start_q;

    bcd_counter4 #(
        .MAX_SCORE(MAX_SCORE)
    ) u_bcd (
        .clk     (clk),
        .reset   (reset),
        .clear   (ctr_clear),
        .inc     (ctr_inc),
        .bin     (score),
        .bin_next(score_next),
        .bcd     (score_bcd)
    );

    always_comb begin
        state_d   = state_q;
        holdoff_d = holdoff_q;
        lives_d   = lives_q;
        hit       = 1'b0;
        ctr_clear = 1'b0;
        ctr_inc   = 1'b0;
        go_over   = 1'b0;

        // Latch only arms in RUN, so it stays clear through HOLD.
        if (frame_tick) begin
            latch_d = 1'b0;
        end else if (state_q == RUN && collide) begin
            latch_d = 1'b1;
        end else begin
            latch_d = latch_q;
        end

        // A miss arriving on the tick itself is kept for the following tick.
        if (state_q == RUN || state_q == HOLD) begin
            pend_d = miss | (pend_q & ~frame_tick);
        end else begin
            pend_d = 1'b0;
        end

        unique case (state_q)
            IDLE, OVER: begin
                if (start_edge) begin
                    state_d   = RUN;
                    ctr_clear = 1'b1;
                    lives_d   = 2'(LIVES);
                    holdoff_d = '0;
                    latch_d   = 1'b0;
                end
            end
            RUN, HOLD: begin
                if (frame_tick) begin
                    if (state_q == RUN && latch_q) begin
                        hit       = 1'b1;
                        ctr_inc   = 1'b1;
                        holdoff_d = HO_LOAD;
                        state_d   = HOLD;
                    end else if (state_q == HOLD) begin
                        if (holdoff_q == '0) begin
                            state_d = RUN;
                        end else begin
                            holdoff_d = holdoff_q - HO_W'(1);
                        end
                    end
                    if (pend_q && lives_q != 2'd0) begin
                        lives_d = lives_q - 2'd1;
                        if (lives_q == 2'd1) begin
                            go_over = 1'b1;
                            state_d = OVER;
                        end
                    end
                end
            end
        endcase
    end

    // Separate block: score_next depends on ctr_inc from the FSM block above.
    always_comb begin
        hi_d = hi_q;
        if (go_over && score_next > hi_q) begin
            hi_d = score_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            start_q   <= 1'b0;
            latch_q   <= 1'b0;
            pend_q    <= 1'b0;
            holdoff_q <= '0;
            lives_q   <= '0;
            hi_q      <= '0;
        end else begin
            state_q   <= state_d;
            start_q   <= start;
            latch_q   <= latch_d;
            pend_q    <= pend_d;
            holdoff_q <= holdoff_d;
            lives_q   <= lives_d;
            hi_q      <= hi_d;
        end
    end

    assign hi_score  = hi_q;
    assign lives     = lives_q;
    assign running   = (state_q == RUN) || (state_q == HOLD);
    assign game_over = (state_q == OVER);

endmodule

// File: tb/tb_game_score_ctrl.sv
module tb_game_score_ctrl;
    import game_pkg::*;

    logic clk = 1'b0;
    logic reset, frame_tick, collide, miss, start;

    logic               hit_a, hit_b;
    logic [SCORE_W-1:0] score_a, score_b, hi_a, hi_b;
    logic [BCD_W-1:0]   bcd_a, bcd_b;
    logic [1:0]         lives_a, lives_b;
    logic               run_a, run_b, over_a, over_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    game_score_ctrl dut_a (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .collide(collide), .miss(miss),
        .start(start), .hit(hit_a), .score(score_a), .score_bcd(bcd_a), .hi_score(hi_a),
        .lives(lives_a), .running(run_a), .game_over(over_a)
    );

    // Short hold-off instance so the saturation run fits in a reasonable cycle count.
    game_score_ctrl #(.HOLDOFF_TICKS(1)) dut_b (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .collide(collide), .miss(miss),
        .start(start), .hit(hit_b), .score(score_b), .score_bcd(bcd_b), .hi_score(hi_b),
        .lives(lives_b), .running(run_b), .game_over(over_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick(output logic ha, output logic hb);
        frame_tick = 1'b1;
        @(negedge clk);
        ha = hit_a;
        hb = hit_b;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic press_start();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    // One catch on dut_a plus the eight hold-off ticks that bring it back to RUN.
    task automatic catch_a(output logic h);
        logic hb, d;
        collide = 1'b1;
        step();
        collide = 1'b0;
        do_tick(h, hb);
        repeat (8) do_tick(d, hb);
    endtask

    task automatic miss_frame();
        logic d1, d2;
        miss = 1'b1;
        step();
        miss = 1'b0;
        do_tick(d1, d2);
    endtask

    task automatic test_reset();
        logic h;
        reset = 1'b0;
        step();
        n_tests++;
        if ({hit_a, score_a, bcd_a, hi_a, lives_a, run_a, over_a} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got score=%0d bcd=%h hi=%0d lives=%0d run=%b over=%b, want all 0",
                     score_a, bcd_a, hi_a, lives_a, run_a, over_a);
        end
        reset = 1'b1;
        step();
        press_start();
        n_tests++;
        if (lives_a !== 2'd3 || run_a !== 1'b1) begin
            n_fail++;
            $display("FAIL start_game: got lives=%0d run=%b, want 3 1", lives_a, run_a);
        end
        for (int i = 0; i < 37; i++) catch_a(h);
        n_tests++;
        if (score_a !== 14'd37 || bcd_a !== 16'h0037 || run_a !== 1'b1) begin
            n_fail++;
            $display("FAIL score_37: got %0d/%h run=%b, want 37/0037 1", score_a, bcd_a, run_a);
        end
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if ({hit_a, score_a, bcd_a, hi_a, lives_a, run_a, over_a} !== '0
            || dut_a.state_q !== IDLE) begin
            n_fail++;
            $display("FAIL async_reset: got score=%0d bcd=%h lives=%0d run=%b state=%0d, want 0 IDLE",
                     score_a, bcd_a, lives_a, run_a, dut_a.state_q);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();
    endtask

    task automatic test_single_hit();
        logic h, hb;
        int   stray;
        apply_reset();
        press_start();
        stray   = 0;
        collide = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (hit_a) stray++;
            step();
        end
        collide = 1'b0;
        do_tick(h, hb);
        n_tests++;
        if (stray !== 0) begin
            n_fail++;
            $display("FAIL hit_outside_tick: got %0d pulses, want 0", stray);
        end
        n_tests++;
        if (h !== 1'b1) begin
            n_fail++;
            $display("FAIL single_hit: got hit=%b, want 1", h);
        end
        n_tests++;
        if (score_a !== 14'd1 || bcd_a !== 16'h0001 || dut_a.state_q !== HOLD) begin
            n_fail++;
            $display("FAIL after_hit: got %0d/%h state=%0d, want 1/0001 HOLD",
                     score_a, bcd_a, dut_a.state_q);
        end
        collide = 1'b1;
        repeat (5) step();
        collide = 1'b0;
        do_tick(h, hb);
        n_tests++;
        if (h !== 1'b0 || score_a !== 14'd1) begin
            n_fail++;
            $display("FAIL hold_ignores: got hit=%b score=%0d, want 0 1", h, score_a);
        end
    endtask

    task automatic test_holdoff();
        logic [19:0] hits;
        logic        h, hb;
        apply_reset();
        press_start();
        collide = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            do_tick(h, hb);
            hits[i] = h;
        end
        collide = 1'b0;
        n_tests++;
        if (hits !== 20'h40201) begin
            n_fail++;
            $display("FAIL holdoff_pattern: got %b, want %b", hits, 20'h40201);
        end
        n_tests++;
        if (score_a !== 14'd3) begin
            n_fail++;
            $display("FAIL holdoff_score: got %0d, want 3", score_a);
        end
    endtask

    task automatic test_saturate();
        logic ha, hb, d1, d2;
        int   nhit;
        apply_reset();
        press_start();
        nhit    = 0;
        collide = 1'b1;
        for (int i = 0; i < 9998; i++) begin
            step();
            do_tick(ha, hb);
            if (hb) nhit++;
            do_tick(d1, d2);
            if (i == 1233) begin
                n_tests++;
                if (score_b !== 14'd1234 || bcd_b !== 16'h1234) begin
                    n_fail++;
                    $display("FAIL bcd_1234: got %0d/%h, want 1234/1234", score_b, bcd_b);
                end
            end
        end
        n_tests++;
        if (nhit !== 9998 || score_b !== 14'd9998 || bcd_b !== 16'h9998) begin
            n_fail++;
            $display("FAIL preload_9998: got hits=%0d score=%0d bcd=%h, want 9998 9998 9998",
                     nhit, score_b, bcd_b);
        end
        for (int k = 0; k < 2; k++) begin
            step();
            do_tick(ha, hb);
            do_tick(d1, d2);
            n_tests++;
            if (hb !== 1'b1 || score_b !== 14'd9999 || bcd_b !== 16'h9999) begin
                n_fail++;
                $display("FAIL saturate_%0d: got hit=%b score=%0d bcd=%h, want 1 9999 9999",
                         k, hb, score_b, bcd_b);
            end
        end
        collide = 1'b0;
    endtask

    task automatic test_last_life();
        logic h, hb;
        apply_reset();
        press_start();
        catch_a(h);
        catch_a(h);
        miss = 1'b1;
        step();
        miss = 1'b0;
        step();
        miss = 1'b1;
        step();
        miss = 1'b0;
        do_tick(h, hb);
        n_tests++;
        if (lives_a !== 2'd2) begin
            n_fail++;
            $display("FAIL double_miss: got lives=%0d, want 2", lives_a);
        end
        miss_frame();
        n_tests++;
        if (lives_a !== 2'd1 || run_a !== 1'b1) begin
            n_fail++;
            $display("FAIL one_life: got lives=%0d run=%b, want 1 1", lives_a, run_a);
        end
        collide = 1'b1;
        step();
        collide = 1'b0;
        miss    = 1'b1;
        step();
        miss = 1'b0;
        do_tick(h, hb);
        n_tests++;
        if (h !== 1'b1 || score_a !== 14'd3 || lives_a !== 2'd0 || over_a !== 1'b1
            || run_a !== 1'b0 || hi_a !== 14'd3) begin
            n_fail++;
            $display("FAIL last_life: got hit=%b score=%0d lives=%0d over=%b run=%b hi=%0d, want 1 3 0 1 0 3",
                     h, score_a, lives_a, over_a, run_a, hi_a);
        end
        collide = 1'b1;
        step();
        collide = 1'b0;
        do_tick(h, hb);
        n_tests++;
        if (h !== 1'b0 || score_a !== 14'd3 || over_a !== 1'b1) begin
            n_fail++;
            $display("FAIL over_frozen: got hit=%b score=%0d over=%b, want 0 3 1", h, score_a, over_a);
        end
    endtask

    task automatic test_hi_score();
        logic h;
        apply_reset();
        press_start();
        for (int i = 0; i < 12; i++) catch_a(h);
        repeat (3) miss_frame();
        n_tests++;
        if (over_a !== 1'b1 || score_a !== 14'd12 || hi_a !== 14'd12) begin
            n_fail++;
            $display("FAIL game1_end: got over=%b score=%0d hi=%0d, want 1 12 12", over_a, score_a, hi_a);
        end
        start = 1'b1;
        step();
        n_tests++;
        if (run_a !== 1'b1 || score_a !== 14'd0 || bcd_a !== 16'h0000 || lives_a !== 2'd3
            || hi_a !== 14'd12) begin
            n_fail++;
            $display("FAIL restart: got run=%b score=%0d lives=%0d hi=%0d, want 1 0 3 12",
                     run_a, score_a, lives_a, hi_a);
        end
        for (int i = 0; i < 5; i++) catch_a(h);
        repeat (3) miss_frame();
        n_tests++;
        if (over_a !== 1'b1 || score_a !== 14'd5 || hi_a !== 14'd12) begin
            n_fail++;
            $display("FAIL game2_end: got over=%b score=%0d hi=%0d, want 1 5 12", over_a, score_a, hi_a);
        end
        repeat (4) step();
        n_tests++;
        if (over_a !== 1'b1 || run_a !== 1'b0) begin
            n_fail++;
            $display("FAIL held_start: got over=%b run=%b, want 1 0", over_a, run_a);
        end
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        n_tests++;
        if (run_a !== 1'b1 || score_a !== 14'd0 || hi_a !== 14'd12) begin
            n_fail++;
            $display("FAIL second_restart: got run=%b score=%0d hi=%0d, want 1 0 12", run_a, score_a, hi_a);
        end
    endtask

    initial begin
        reset      = 1'b1;
        frame_tick = 1'b0;
        collide    = 1'b0;
        miss       = 1'b0;
        start      = 1'b0;
        #2;
        test_reset();
        test_single_hit();
        test_holdoff();
        test_saturate();
        test_last_life();
        test_hi_score();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
